// File: rtl/mux_serializer_ctrl_pkg.sv
// mux_serializer_ctrl_pkg
//   Shared definitions for the byte serializer that drives an external 8:1 mux:
//   FSM state encoding, byte and index widths, and helpers giving the first and
//   final bit index for either bit order.
package mux_serializer_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Index of the first bit sent after a load.
  function automatic logic [IDX_W-1:0] first_idx(input bit msb_first);
    return msb_first ? 3'd7 : 3'd0;
  endfunction

  // Index of the last bit of a byte.
  function automatic logic [IDX_W-1:0] final_idx(input bit msb_first);
    return msb_first ? 3'd0 : 3'd7;
  endfunction

endpackage

// File: rtl/bit_index_counter.sv
// bit_index_counter
//   3-bit bit-index register that steps up (LSB first) or down (MSB first).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (index clears to 0)
//     load        restart at the first index for the configured bit order
//     adv         step one index toward the final index
//     idx         current index (drives the mux select)
//     is_final    idx is the final index of the byte
//   The caller never asserts adv at the final index, so the index never wraps.
module bit_index_counter
  import mux_serializer_ctrl_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  output logic [IDX_W-1:0] idx,
  output logic             is_final
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (load) begin
      idx <= first_idx(MSB_FIRST);
    end else if (adv) begin
      idx <= MSB_FIRST ? idx - 3'd1 : idx + 3'd1;
    end
  end

  assign is_final = (idx == final_idx(MSB_FIRST));

endmodule

// File: rtl/mux_serializer_ctrl.sv
// mux_serializer_ctrl
//   Serializes a byte through an external 8:1 mux: the byte is presented on
//   mux_in, the bit index on mux_sel, and the mux result mux_out is sampled
//   into ser_bit one index per unstalled cycle.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     load_data/valid/ready byte handshake; a transfer happens when valid & ready
//     stall                 hold the current index and skip the sample
//     mux_in, mux_sel       registered byte and bit index for the external mux
//     mux_out               external mux result for the current mux_sel
//     ser_bit/valid/last    registered sample, its qualifier, last-bit flag
//     busy                  a byte is being shifted out
//   Parameter MSB_FIRST: 0 sends index 0..7, 1 sends index 7..0.
module mux_serializer_ctrl
  import mux_serializer_ctrl_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              stall,
  output logic [BYTE_W-1:0] mux_in,
  output logic [IDX_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  state_t state;
  logic   at_final;
  logic   sample;
  logic   transfer;
  logic   adv;

  // A sample is taken on every unstalled edge while shifting.
  assign sample   = (state == ST_SHIFT) && !stall;

  // Ready in IDLE, or on the final sample so the next byte follows with no gap.
  // Gated by rst_n so ready reads low while reset is held.
  assign load_ready = rst_n && ((state == ST_IDLE) || (at_final && sample));
  assign transfer   = load_valid && load_ready;

  // The final index is left only by a reload or a return to IDLE.
  assign adv = sample && !at_final;

  bit_index_counter #(
    .MSB_FIRST (MSB_FIRST)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (transfer),
    .adv      (adv),
    .idx      (mux_sel),
    .is_final (at_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mux_in    <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      ser_valid <= sample;
      ser_last  <= sample && at_final;
      if (sample) begin
        ser_bit <= mux_out;
      end
      if (transfer) begin
        mux_in <= load_data;
      end
      if (transfer) begin
        state <= ST_SHIFT;
      end else if (sample && at_final) begin
        state <= ST_IDLE;
      end
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// tb_mux_serializer_ctrl
//   Two instances (LSB first and MSB first) share one stimulus stream; each has
//   its own behavioural 8:1 mux. A byte-level reference model (bits remaining
//   in the current byte) predicts acceptance, and every predicted sample is
//   pushed with its expected cycle into a scoreboard that a monitor drains.
module tb_mux_serializer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] load_data = 8'h00;
  logic       load_valid = 1'b0;
  logic       stall = 1'b0;

  logic       ready_l, ser_bit_l, ser_valid_l, ser_last_l, busy_l, mux_out_l;
  logic [7:0] mux_in_l;
  logic [2:0] mux_sel_l;
  logic       ready_m, ser_bit_m, ser_valid_m, ser_last_m, busy_m, mux_out_m;
  logic [7:0] mux_in_m;
  logic [2:0] mux_sel_m;

  assign mux_out_l = mux_in_l[mux_sel_l];
  assign mux_out_m = mux_in_m[mux_sel_m];

  mux_serializer_ctrl #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_l), .stall(stall), .mux_in(mux_in_l), .mux_sel(mux_sel_l),
    .mux_out(mux_out_l), .ser_bit(ser_bit_l), .ser_valid(ser_valid_l),
    .ser_last(ser_last_l), .busy(busy_l)
  );

  mux_serializer_ctrl #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_m), .stall(stall), .mux_in(mux_in_m), .mux_sel(mux_sel_m),
    .mux_out(mux_out_m), .ser_bit(ser_bit_m), .ser_valid(ser_valid_m),
    .ser_last(ser_last_m), .busy(busy_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic bl;
    logic bm;
    logic last;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_byte = 8'h00;
  int         m_rem = 0;
  logic       exp_busy = 1'b0;
  logic [2:0] exp_sel_l = 3'd0;
  logic [2:0] exp_sel_m = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; applies inputs for the next rising edge and
  // advances the reference model across that edge.
  task automatic step(input logic lv, input logic [7:0] d, input logic st, output bit accepted);
    bit   ready;
    int   k;
    exp_t e;
    load_valid = lv;
    load_data  = d;
    stall      = st;
    #1;
    ready = (m_rem == 0) || (m_rem == 1 && !st);
    check("load_ready_lsb", ready_l, ready);
    check("load_ready_msb", ready_m, ready);
    accepted = lv && ready;
    if (m_rem > 0 && !st) begin
      k      = 8 - m_rem;
      e.cyc  = cyc + 1;
      e.bl   = m_byte[k];
      e.bm   = m_byte[7-k];
      e.last = (m_rem == 1);
      sbq.push_back(e);
      m_rem--;
    end
    if (accepted) begin
      m_byte = d;
      m_rem  = 8;
    end
    exp_busy = (m_rem > 0);
    if (m_rem > 0) begin
      k = 8 - m_rem;
      exp_sel_l = k[2:0];
      exp_sel_m = 3'(7 - k);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, acc);
  endtask

  task automatic check_reset();
    check("rst_mux_in", mux_in_l, 8'h00);
    check("rst_mux_sel_lsb", mux_sel_l, 3'd0);
    check("rst_mux_sel_msb", mux_sel_m, 3'd0);
    check("rst_ser_bit", ser_bit_l, 1'b0);
    check("rst_ser_valid", ser_valid_l, 1'b0);
    check("rst_ser_last", ser_last_l, 1'b0);
    check("rst_busy", busy_l, 1'b0);
    check("rst_load_ready_lsb", ready_l, 1'b0);
    check("rst_load_ready_msb", ready_m, 1'b0);
  endtask

  // Asserted between edges to exercise the asynchronous path; the pending
  // byte is dropped from the model.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    sbq.delete();
    m_rem    = 0;
    exp_busy = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the serial output of both instances against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_sample: no ser_valid in cycle %0d (now %0d)", sbq[0].cyc, cyc);
        mon_e = sbq.pop_front();
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        mon_e = sbq.pop_front();
        check("ser_valid_lsb", ser_valid_l, 1'b1);
        check("ser_valid_msb", ser_valid_m, 1'b1);
        check("ser_bit_lsb", ser_bit_l, mon_e.bl);
        check("ser_bit_msb", ser_bit_m, mon_e.bm);
        check("ser_last_lsb", ser_last_l, mon_e.last);
        check("ser_last_msb", ser_last_m, mon_e.last);
      end else begin
        check("ser_valid_idle_lsb", ser_valid_l, 1'b0);
        check("ser_valid_idle_msb", ser_valid_m, 1'b0);
        check("ser_last_idle_lsb", ser_last_l, 1'b0);
        check("ser_last_idle_msb", ser_last_m, 1'b0);
      end
      check("busy_lsb", busy_l, exp_busy);
      check("busy_msb", busy_m, exp_busy);
      if (exp_busy) begin
        check("mux_sel_lsb", mux_sel_l, exp_sel_l);
        check("mux_sel_msb", mux_sel_m, exp_sel_m);
        check("mux_in_lsb", mux_in_l, m_byte);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int tries;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    // 8'hA5 (LSB instance: 1,0,1,0,0,1,0,1) / 8'h81 (MSB instance pattern)
    step(1'b1, 8'hA5, 1'b0, acc);
    idle(10);
    step(1'b1, 8'h81, 1'b0, acc);
    idle(10);

    // Back-to-back: 8'h0F then 8'hF0 held until it is taken at the final index.
    step(1'b1, 8'h0F, 1'b0, acc);
    tries = 0;
    do begin
      step(1'b1, 8'hF0, 1'b0, acc);
      tries++;
    end while (!acc && tries < 12);
    check("b2b_accepted", {31'd0, acc}, 32'd1);
    idle(10);

    // Three stall cycles at index 4.
    step(1'b1, 8'h3C, 1'b0, acc);
    idle(4);
    repeat (3) step(1'b0, 8'h00, 1'b1, acc);
    idle(10);

    // Stall with load_valid at the final index: no transfer until stall drops.
    step(1'b1, 8'h55, 1'b0, acc);
    idle(7);
    repeat (2) step(1'b1, 8'hAA, 1'b1, acc);
    step(1'b1, 8'hAA, 1'b0, acc);
    idle(10);

    // Stall while idle does not block a transfer.
    step(1'b1, 8'h6B, 1'b1, acc);
    idle(10);

    // Asynchronous reset at index 5 of 8'hFF, then 8'h00.
    step(1'b1, 8'hFF, 1'b0, acc);
    idle(5);
    async_reset();
    step(1'b1, 8'h00, 1'b0, acc);
    idle(10);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0), acc);
    end
    idle(12);
    check("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
